// File: rtl/spi_reg_pkg.sv
// rtl/spi_reg_pkg.sv - shared types and constants for the SPI register-access sequencer
//
// Purpose: FSM state encoding, read/write flag values and the dummy byte that is
// shifted out during the data phase of a read.
package spi_reg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CMD    = 3'd1,
    ST_HOLD0  = 3'd2,
    ST_DATA   = 3'd3,
    ST_HOLD1  = 3'd4,
    ST_RXWAIT = 3'd5,
    ST_RSP    = 3'd6
  } state_e;

  localparam logic       RW_READ    = 1'b1;
  localparam logic       RW_WRITE   = 1'b0;
  localparam logic [7:0] READ_DUMMY = 8'h00;

endpackage

// File: rtl/spi_reg_seq.sv
// rtl/spi_reg_seq.sv - register read/write request to two-byte SPI transaction sequencer
//
// Purpose: accepts one register request at a time and drives a byte-level SPI master
// with a command byte {rw, addr} followed by a data byte (write data, or a dummy for
// reads). The byte received during the data phase is returned as read data. A
// timeout guarantees a response even if the master never becomes ready.
//
// Ports:
//   i_Clk, i_Rst_L                    clock, asynchronous active-low reset
//   i_Req_Valid / o_Req_Ready         request handshake
//   i_Req_RW, i_Req_Addr, i_Req_WData request fields (captured on accept)
//   o_Rsp_DV, o_Rsp_RData, o_Rsp_Err  one-cycle response with read data / timeout flag
//   o_TX_Count                        bytes per chip-select, constant 2
//   o_TX_Byte, o_TX_DV, i_TX_Ready    byte path to the SPI master
//   i_RX_DV, i_RX_Byte                received-byte pulses from the SPI master
module spi_reg_seq
  import spi_reg_pkg::*;
#(
  parameter int ADDR_WIDTH       = 7,
  parameter int MAX_BYTES_PER_CS = 2,
  parameter int TIMEOUT_CLKS     = 4096
) (
  input  logic                                    i_Clk,
  input  logic                                    i_Rst_L,
  input  logic                                    i_Req_Valid,
  output logic                                    o_Req_Ready,
  input  logic                                    i_Req_RW,
  input  logic [ADDR_WIDTH-1:0]                   i_Req_Addr,
  input  logic [7:0]                              i_Req_WData,
  output logic                                    o_Rsp_DV,
  output logic [7:0]                              o_Rsp_RData,
  output logic                                    o_Rsp_Err,
  output logic [$clog2(MAX_BYTES_PER_CS+1)-1:0]   o_TX_Count,
  output logic [7:0]                              o_TX_Byte,
  output logic                                    o_TX_DV,
  input  logic                                    i_TX_Ready,
  input  logic                                    i_RX_DV,
  input  logic [7:0]                              i_RX_Byte
);

  localparam int CNT_W = $clog2(MAX_BYTES_PER_CS + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CLKS + 1);

  state_e                  state_q, state_d;
  logic                    rw_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [7:0]              wdata_q;
  logic [1:0]              rx_cnt_q, rx_cnt_d;
  logic [7:0]              rx_byte_q, rx_byte_d;
  logic [TO_W-1:0]         to_cnt_q, to_cnt_d;

  logic                    req_ready_q, req_ready_d;
  logic                    tx_dv_q, tx_dv_d;
  logic [7:0]              tx_byte_q, tx_byte_d;
  logic                    rsp_dv_q, rsp_dv_d;
  logic [7:0]              rsp_rdata_q, rsp_rdata_d;
  logic                    rsp_err_q, rsp_err_d;

  logic                    accept;
  logic                    busy;
  logic                    timeout;
  logic                    rx_hit;
  logic                    rx_latch;
  logic [7:0]              cmd_byte;
  logic [7:0]              data_byte;

  assign accept    = i_Req_Valid && req_ready_q;
  assign busy      = (state_q != ST_IDLE) && (state_q != ST_RSP);
  assign timeout   = busy && (to_cnt_q == TO_W'(TIMEOUT_CLKS - 1));
  assign cmd_byte  = {rw_q, addr_q};
  assign data_byte = (rw_q == RW_READ) ? READ_DUMMY : wdata_q;

  // Stray RX pulses while idle are not counted; accept restarts the count so any
  // pulse arriving before a new transaction cannot shift byte alignment.
  assign rx_hit   = i_RX_DV && (state_q != ST_IDLE);
  assign rx_latch = rx_hit && (rx_cnt_q == 2'd1);

  always_comb begin
    rx_cnt_d = rx_cnt_q;
    if (accept) begin
      rx_cnt_d = 2'd0;
    end else if (rx_hit && (rx_cnt_q != 2'd3)) begin
      rx_cnt_d = rx_cnt_q + 2'd1;
    end
  end

  assign rx_byte_d = rx_latch ? i_RX_Byte : rx_byte_q;

  always_comb begin
    to_cnt_d = to_cnt_q;
    if (accept) begin
      to_cnt_d = '0;
    end else if (busy && !timeout) begin
      to_cnt_d = to_cnt_q + TO_W'(1);
    end
  end

  // State and datapath registers.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q     <= ST_IDLE;
      rw_q        <= RW_WRITE;
      addr_q      <= '0;
      wdata_q     <= 8'h00;
      rx_cnt_q    <= 2'd0;
      rx_byte_q   <= 8'h00;
      to_cnt_q    <= '0;
      req_ready_q <= 1'b1;
      tx_dv_q     <= 1'b0;
      tx_byte_q   <= 8'h00;
      rsp_dv_q    <= 1'b0;
      rsp_rdata_q <= 8'h00;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_byte_q   <= rx_byte_d;
      to_cnt_q    <= to_cnt_d;
      req_ready_q <= req_ready_d;
      tx_dv_q     <= tx_dv_d;
      tx_byte_q   <= tx_byte_d;
      rsp_dv_q    <= rsp_dv_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      if (accept) begin
        rw_q    <= i_Req_RW;
        addr_q  <= i_Req_Addr;
        wdata_q <= i_Req_WData;
      end
    end
  end

  // Next-state logic. The timeout overrides every busy state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept) state_d = ST_CMD;
      ST_CMD:    if (i_TX_Ready) state_d = ST_HOLD0;
      ST_HOLD0:  state_d = ST_DATA;
      ST_DATA:   if (i_TX_Ready) state_d = ST_HOLD1;
      ST_HOLD1:  state_d = ST_RXWAIT;
      ST_RXWAIT: if (rx_cnt_d >= 2'd2) state_d = ST_RSP;
      ST_RSP:    state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    if (timeout) begin
      state_d = ST_RSP;
    end
  end

  // Output next values; outputs are registered so they follow the state transition.
  always_comb begin
    req_ready_d = (state_d == ST_IDLE);
    tx_dv_d     = 1'b0;
    tx_byte_d   = tx_byte_q;
    rsp_dv_d    = (state_d == ST_RSP);
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    if (!timeout) begin
      if ((state_q == ST_CMD) && i_TX_Ready) begin
        tx_dv_d   = 1'b1;
        tx_byte_d = cmd_byte;
      end else if ((state_q == ST_DATA) && i_TX_Ready) begin
        tx_dv_d   = 1'b1;
        tx_byte_d = data_byte;
      end
    end
    if (state_d == ST_RSP) begin
      rsp_err_d   = timeout;
      rsp_rdata_d = (timeout || (rw_q == RW_WRITE)) ? 8'h00 : rx_byte_d;
    end
  end

  assign o_Req_Ready = req_ready_q;
  assign o_TX_DV     = tx_dv_q;
  assign o_TX_Byte   = tx_byte_q;
  assign o_TX_Count  = CNT_W'(2);
  assign o_Rsp_DV    = rsp_dv_q;
  assign o_Rsp_RData = rsp_rdata_q;
  assign o_Rsp_Err   = rsp_err_q;

endmodule

// File: tb/tb_spi_reg_seq.sv
// tb/tb_spi_reg_seq.sv - scoreboard bench for spi_reg_seq with a byte-level SPI master stub
module tb_spi_reg_seq;

  typedef struct {
    logic       err;
    logic [7:0] rdata;
    int         acc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid, req_ready, req_rw;
  logic [6:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_dv, rsp_err;
  logic [7:0] rsp_rdata;
  logic [1:0] tx_count;
  logic [7:0] tx_byte;
  logic       tx_dv, tx_ready;
  logic       rx_dv;
  logic [7:0] rx_byte;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_rx_cyc = -10;

  logic       stall = 1'b0;
  logic       stray_req = 1'b0;
  exp_t       rsp_q[$];
  logic [7:0] tx_exp[$];
  logic [7:0] reply_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spi_reg_seq #(
    .ADDR_WIDTH(7),
    .MAX_BYTES_PER_CS(2),
    .TIMEOUT_CLKS(64)
  ) dut (
    .i_Clk(clk),
    .i_Rst_L(rst_n),
    .i_Req_Valid(req_valid),
    .o_Req_Ready(req_ready),
    .i_Req_RW(req_rw),
    .i_Req_Addr(req_addr),
    .i_Req_WData(req_wdata),
    .o_Rsp_DV(rsp_dv),
    .o_Rsp_RData(rsp_rdata),
    .o_Rsp_Err(rsp_err),
    .o_TX_Count(tx_count),
    .o_TX_Byte(tx_byte),
    .o_TX_DV(tx_dv),
    .i_TX_Ready(tx_ready),
    .i_RX_DV(rx_dv),
    .i_RX_Byte(rx_byte)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ready"}, req_ready, 1);
    check({tag, "_tx_dv"}, tx_dv, 0);
    check({tag, "_tx_byte"}, tx_byte, 0);
    check({tag, "_tx_count"}, tx_count, 2);
    check({tag, "_rsp_dv"}, rsp_dv, 0);
    check({tag, "_rsp_rdata"}, rsp_rdata, 0);
    check({tag, "_rsp_err"}, rsp_err, 0);
  endtask

  // Byte-level master stub: takes a byte on DV, drops ready, and after a random
  // shift time returns a received byte. Byte 1 of each transaction returns the
  // slave reply scheduled by the driver; byte 0 returns random garbage.
  initial begin
    int pend;
    int idx;
    logic [7:0] cur;
    pend = 0;
    idx = 0;
    cur = 8'h00;
    tx_ready = 1'b1;
    rx_dv = 1'b0;
    rx_byte = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      rx_dv = 1'b0;
      if (!rst_n) begin
        pend = 0;
        idx = 0;
        tx_ready = !stall;
      end else begin
        if (pend > 0) begin
          pend--;
          if (pend == 0) begin
            rx_dv = 1'b1;
            rx_byte = cur;
            last_rx_cyc = cyc;
          end
        end else if (stray_req) begin
          rx_dv = 1'b1;
          rx_byte = 8'hEE;
          stray_req = 1'b0;
        end
        if (pend == 0) tx_ready = !stall;
        if (tx_dv) begin
          if (tx_exp.size() == 0) begin
            total++;
            bad++;
            $display("FAIL tx_unexpected: got byte 0x%0h expected no byte (cycle %0d)", tx_byte, cyc);
          end else begin
            check("tx_byte", tx_byte, tx_exp.pop_front());
          end
          tx_ready = 1'b0;
          pend = $urandom_range(2, 8);
          if (idx == 0) cur = 8'($urandom);
          else cur = (reply_q.size() != 0) ? reply_q.pop_front() : 8'h00;
          idx ^= 1;
        end
      end
    end
  end

  // Response and handshake monitor.
  initial begin
    logic prev_ready;
    logic prev_rsp;
    logic acc_pend;
    logic [7:0] last_tx;
    exp_t e;
    prev_ready = 1'b1;
    prev_rsp = 1'b0;
    acc_pend = 1'b0;
    last_tx = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_ready = 1'b1;
        prev_rsp = 1'b0;
        acc_pend = 1'b0;
        last_tx = 8'h00;
        continue;
      end
      if (acc_pend) check("ready_drop", req_ready, 0);
      if (req_ready && !prev_ready) check("ready_rise_after_rsp", prev_rsp, 1);
      if (tx_dv) last_tx = tx_byte;
      else check("tx_byte_hold", tx_byte, last_tx);
      if (rsp_dv) begin
        if (rsp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rsp_unexpected: got rsp rdata 0x%0h err %0d expected none (cycle %0d)", rsp_rdata, rsp_err, cyc);
        end else begin
          e = rsp_q.pop_front();
          check("rsp_err", rsp_err, e.err);
          check("rsp_rdata", rsp_rdata, e.rdata);
          check("tx_count", tx_count, 2);
          if (e.err) check("timeout_latency", cyc - e.acc, 64);
          else check("rsp_latency", cyc - last_rx_cyc, 1);
        end
      end
      acc_pend = req_valid && req_ready;
      prev_ready = req_ready;
      prev_rsp = rsp_dv;
    end
  end

  // Issue one request; expectations are pushed when the accept is certain.
  task automatic send(input logic rw, input logic [6:0] addr, input logic [7:0] wd,
                      input logic keep, input logic to, input logic [7:0] reply);
    int n;
    exp_t e;
    n = 0;
    req_valid = 1'b1;
    req_rw = rw;
    req_addr = addr;
    req_wdata = wd;
    while (!req_ready && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!req_ready) begin
      total++;
      bad++;
      $display("FAIL accept_wait: got no ready after %0d cycles expected ready", n);
      req_valid = 1'b0;
      return;
    end
    e.err = to;
    e.rdata = (to || !rw) ? 8'h00 : reply;
    e.acc = cyc + 1;
    rsp_q.push_back(e);
    if (!to) begin
      tx_exp.push_back({rw, addr});
      tx_exp.push_back(rw ? 8'h00 : wd);
      reply_q.push_back(reply);
    end
    @(posedge clk);
    #1;
    if (!keep) req_valid = 1'b0;
    req_rw = 1'($urandom);
    req_addr = 7'($urandom);
    req_wdata = 8'($urandom);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((rsp_q.size() != 0 || !req_ready) && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 400) begin
      total++;
      bad++;
      $display("FAIL drain_wait: got %0d responses pending expected 0", rsp_q.size());
      rsp_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish by time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic keep;
    logic prev_keep;
    req_valid = 1'b0;
    req_rw = 1'b0;
    req_addr = 7'h00;
    req_wdata = 8'h00;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    send(1'b0, 7'h05, 8'hA5, 1'b0, 1'b0, 8'h3C);
    wait_done();
    send(1'b1, 7'h12, 8'h00, 1'b0, 1'b0, 8'h3C);
    wait_done();

    send(1'b1, 7'h21, 8'h00, 1'b1, 1'b0, 8'h3C);
    send(1'b1, 7'h33, 8'h00, 1'b0, 1'b0, 8'h3C);
    wait_done();

    stall = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    send(1'b1, 7'h40, 8'h00, 1'b0, 1'b1, 8'h00);
    wait_done();
    stall = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    send(1'b0, 7'h11, 8'h22, 1'b0, 1'b0, 8'h3C);
    n = 0;
    while (!tx_dv && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("mid_reset_first_dv", tx_dv, 1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("mid_reset");
    rsp_q.delete();
    tx_exp.delete();
    reply_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(1'b0, 7'h7F, 8'h01, 1'b0, 1'b0, 8'h3C);
    wait_done();

    stray_req = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    send(1'b1, 7'h12, 8'h00, 1'b0, 1'b0, 8'h3C);
    wait_done();

    prev_keep = 1'b0;
    for (int i = 0; i < 24; i++) begin
      keep = (i != 23) && ($urandom_range(0, 3) == 0);
      if (!prev_keep) begin
        if ($urandom_range(0, 3) == 0) begin
          wait_done();
          stray_req = 1'b1;
          repeat (3) @(posedge clk);
          #1;
        end else begin
          repeat ($urandom_range(0, 4)) @(posedge clk);
          #1;
        end
      end
      send(1'($urandom), 7'($urandom), 8'($urandom), keep, 1'b0, 8'($urandom));
      prev_keep = keep;
    end
    wait_done();
    repeat (4) @(posedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
